mm_addr_gen: RTL



---
 rtl/mm_addr_gen_pkg.sv | 11 +
 rtl/mm_addr_gen_if.sv | 61 ++++++
 rtl/mm_addr_gen_loop_cnt.sv | 25 ++
 rtl/mm_addr_gen.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/mm_addr_gen_pkg.sv
// Shared types and default widths for the MM address sequencer.
package mm_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} mm_state_e;

    localparam int IN_AW_DEF  = 11;
    localparam int W_AW_DEF   = 13;
    localparam int OUT_AW_DEF = 11;
    localparam int CI_W_DEF   = 8;
    localparam int CO_W_DEF   = 8;
    localparam int N_W_DEF    = 16;
endpackage

// File: rtl/mm_addr_gen_if.sv
// Command/beat bundle between layer scheduler, mm_addr_gen and buffer controllers.
// MM_ADDR_GEN_PERF_EN adds the perf_beats/perf_stalls counters to the bundle.
interface mm_addr_gen_if
    import mm_pkg::*;
#(
    parameter int IN_AW  = IN_AW_DEF,
    parameter int W_AW   = W_AW_DEF,
    parameter int OUT_AW = OUT_AW_DEF,
    parameter int CI_W   = CI_W_DEF,
    parameter int CO_W   = CO_W_DEF,
    parameter int N_W    = N_W_DEF
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic [IN_AW-1:0]  cmd_in_base;
    logic [W_AW-1:0]   cmd_w_base;
    logic [OUT_AW-1:0] cmd_out_base;
    logic [CI_W-1:0]   cmd_ci;
    logic [CO_W-1:0]   cmd_co;
    logic [N_W-1:0]    cmd_n;
    logic              abort;
    logic              beat_valid;
    logic              beat_ready;
    logic [IN_AW-1:0]  beat_in_addr;
    logic [W_AW-1:0]   beat_w_addr;
    logic [OUT_AW-1:0] beat_out_addr;
    logic              beat_first;
    logic              beat_last;
    logic              busy;
    logic              done;
`ifdef MM_ADDR_GEN_PERF_EN
    logic [31:0]       perf_beats;
    logic [31:0]       perf_stalls;

    modport slave (
        input  cmd_valid, cmd_in_base, cmd_w_base, cmd_out_base, cmd_ci, cmd_co, cmd_n,
               abort, beat_ready,
        output cmd_ready, beat_valid, beat_in_addr, beat_w_addr, beat_out_addr,
               beat_first, beat_last, busy, done, perf_beats, perf_stalls
    );
    modport master (
        output cmd_valid, cmd_in_base, cmd_w_base, cmd_out_base, cmd_ci, cmd_co, cmd_n,
               abort, beat_ready,
        input  cmd_ready, beat_valid, beat_in_addr, beat_w_addr, beat_out_addr,
               beat_first, beat_last, busy, done, perf_beats, perf_stalls
    );
`else
    modport slave (
        input  cmd_valid, cmd_in_base, cmd_w_base, cmd_out_base, cmd_ci, cmd_co, cmd_n,
               abort, beat_ready,
        output cmd_ready, beat_valid, beat_in_addr, beat_w_addr, beat_out_addr,
               beat_first, beat_last, busy, done
    );
    modport master (
        output cmd_valid, cmd_in_base, cmd_w_base, cmd_out_base, cmd_ci, cmd_co, cmd_n,
               abort, beat_ready,
        input  cmd_ready, beat_valid, beat_in_addr, beat_w_addr, beat_out_addr,
               beat_first, beat_last, busy, done
    );
`endif
endinterface

// File: rtl/mm_addr_gen_loop_cnt.sv
// One level of the loop nest: counts 0..last, wraps to 0 and flags the wrap.
module mm_loop_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] last,
    output logic [W-1:0] cnt,
    output logic         wrap
);
    logic at_last;

    assign at_last = (cnt == last);
    assign wrap    = en && at_last;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_last ? '0 : cnt + W'(1);
        end
    end
endmodule

// File: rtl/mm_addr_gen.sv
// Matrix-multiply address sequencer: walks N x Co x Ci and emits one beat per MAC step.
// Optional build macro MM_ADDR_GEN_PERF_EN adds saturating beat/stall counters.
module mm_addr_gen
    import mm_pkg::*;
#(
    parameter int IN_AW  = IN_AW_DEF,
    parameter int W_AW   = W_AW_DEF,
    parameter int OUT_AW = OUT_AW_DEF,
    parameter int CI_W   = CI_W_DEF,
    parameter int CO_W   = CO_W_DEF,
    parameter int N_W    = N_W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    mm_addr_gen_if.slave bus
);
    mm_state_e         state;
    logic [CI_W-1:0]   ci_r, ci_last;
    logic [CO_W-1:0]   co_last;
    logic [N_W-1:0]    n_last;
    logic [IN_AW-1:0]  in_row, in_addr, in_row_nxt;
    logic [W_AW-1:0]   w_base_r, w_addr;
    logic [OUT_AW-1:0] out_addr;
    logic              cmd_ready, beat_valid, beat_first, beat_last, busy, done;
    logic [CI_W-1:0]   i_cnt;
    logic [CO_W-1:0]   o_cnt;
    logic [N_W-1:0]    n_cnt;
    logic              i_wrap, o_wrap, n_wrap;
    logic              accept, fire, abort_run, zero_size, cnt_clr, cnt_en;
    logic              unused_cnt;

    assign accept     = bus.cmd_valid && cmd_ready;
    assign fire       = beat_valid && bus.beat_ready;
    assign abort_run  = bus.abort && (state != IDLE);
    assign zero_size  = (bus.cmd_ci == '0) || (bus.cmd_co == '0) || (bus.cmd_n == '0);
    // abort wins over a simultaneous handshake, so counters clear instead of stepping
    assign cnt_clr    = accept || abort_run;
    assign cnt_en     = fire && !abort_run;
    assign in_row_nxt = in_row + IN_AW'(ci_r);
    assign unused_cnt = ^{o_cnt, n_cnt};

    mm_loop_cnt #(.W(CI_W)) u_i_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(cnt_en),
        .last(ci_last), .cnt(i_cnt), .wrap(i_wrap)
    );
    mm_loop_cnt #(.W(CO_W)) u_o_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(i_wrap),
        .last(co_last), .cnt(o_cnt), .wrap(o_wrap)
    );
    mm_loop_cnt #(.W(N_W)) u_n_cnt (
        .clk(clk), .rst(rst), .clr(cnt_clr), .en(o_wrap),
        .last(n_last), .cnt(n_cnt), .wrap(n_wrap)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            ci_r       <= '0;
            ci_last    <= '0;
            co_last    <= '0;
            n_last     <= '0;
            in_row     <= '0;
            in_addr    <= '0;
            w_base_r   <= '0;
            w_addr     <= '0;
            out_addr   <= '0;
            cmd_ready  <= 1'b0;
            beat_valid <= 1'b0;
            beat_first <= 1'b0;
            beat_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    cmd_ready <= 1'b1;
                    if (accept) begin
                        ci_r      <= bus.cmd_ci;
                        ci_last   <= bus.cmd_ci - CI_W'(1);
                        co_last   <= bus.cmd_co - CO_W'(1);
                        n_last    <= bus.cmd_n - N_W'(1);
                        in_row    <= bus.cmd_in_base;
                        in_addr   <= bus.cmd_in_base;
                        w_base_r  <= bus.cmd_w_base;
                        w_addr    <= bus.cmd_w_base;
                        out_addr  <= bus.cmd_out_base;
                        cmd_ready <= 1'b0;
                        busy      <= 1'b1;
                        if (zero_size) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state      <= RUN;
                            beat_valid <= 1'b1;
                            beat_first <= 1'b1;
                            beat_last  <= (bus.cmd_ci == CI_W'(1));
                        end
                    end
                end
                RUN: begin
                    if (abort_run || n_wrap) begin
                        state      <= DONE;
                        beat_valid <= 1'b0;
                        beat_first <= 1'b0;
                        beat_last  <= 1'b0;
                        done       <= 1'b1;
                    end else if (fire) begin
                        // next i is 0 exactly when this beat wrapped i
                        beat_first <= i_wrap;
                        beat_last  <= i_wrap ? (ci_last == '0) : ((i_cnt + CI_W'(1)) == ci_last);
                        if (o_wrap) begin
                            in_row   <= in_row_nxt;
                            in_addr  <= in_row_nxt;
                            w_addr   <= w_base_r;
                            out_addr <= out_addr + OUT_AW'(1);
                        end else if (i_wrap) begin
                            in_addr  <= in_row;
                            w_addr   <= w_addr + W_AW'(1);
                            out_addr <= out_addr + OUT_AW'(1);
                        end else begin
                            in_addr <= in_addr + IN_AW'(1);
                            w_addr  <= w_addr + W_AW'(1);
                        end
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    cmd_ready <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.cmd_ready     = cmd_ready;
    assign bus.beat_valid    = beat_valid;
    assign bus.beat_in_addr  = in_addr;
    assign bus.beat_w_addr   = w_addr;
    assign bus.beat_out_addr = out_addr;
    assign bus.beat_first    = beat_first;
    assign bus.beat_last     = beat_last;
    assign bus.busy          = busy;
    assign bus.done          = done;

`ifdef MM_ADDR_GEN_PERF_EN
    logic [31:0] perf_beats, perf_stalls;

    always_ff @(posedge clk) begin
        if (rst || accept) begin
            perf_beats  <= '0;
            perf_stalls <= '0;
        end else begin
            if (fire && (perf_beats != '1)) begin
                perf_beats <= perf_beats + 32'd1;
            end
            if (beat_valid && !bus.beat_ready && (perf_stalls != '1)) begin
                perf_stalls <= perf_stalls + 32'd1;
            end
        end
    end

    assign bus.perf_beats  = perf_beats;
    assign bus.perf_stalls = perf_stalls;
`endif
endmodule
